// File: rtl/mac_result_serializer.sv
// mac_result_serializer: sends a captured MAC result to the UART one byte at a time, with a busy handshake for every byte.
module mac_result_serializer #(
  parameter int DATA_WIDTH     = 48,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int ACCEPT_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  result_valid,
  output logic                  ready,
  input  logic                  tx_busy,
  output logic                  tx_start_transmission,
  output logic [7:0]            tx_data_in,
  output logic                  frame_done,
  output logic                  overrun
);
  localparam int BW = $clog2(NUM_BYTES) + 1;
  localparam int TW = $clog2(ACCEPT_TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, ARM, START, WAIT_HI, WAIT_LO} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         byte_cnt;
  logic [TW-1:0]         to_cnt;
  logic [7:0]            cur_byte;
  logic                  byte_done;
  logic                  last_byte;
  assign cur_byte  = LSB_FIRST ? shreg[7:0] : shreg[DATA_WIDTH-1 -: 8];
  assign last_byte = byte_cnt == BW'(NUM_BYTES - 1);
  // A byte is finished once busy falls, or when the UART never acknowledged it in time.
  assign byte_done = !tx_busy && (state == WAIT_LO ||
                     (state == WAIT_HI && to_cnt == TW'(ACCEPT_TIMEOUT - 1)));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      ready                 <= 1'b1;
      tx_start_transmission <= 1'b0;
      tx_data_in            <= '0;
      frame_done            <= 1'b0;
      overrun               <= 1'b0;
      shreg                 <= '0;
      byte_cnt              <= '0;
      to_cnt                <= '0;
    end else begin
      tx_start_transmission <= 1'b0;
      frame_done            <= 1'b0;
      if (result_valid && !ready) overrun <= 1'b1;
      if (byte_done) begin
        shreg      <= LSB_FIRST ? shreg >> 8 : shreg << 8;
        byte_cnt   <= byte_cnt + 1'b1;
        state      <= last_byte ? IDLE : ARM;
        ready      <= last_byte;
        frame_done <= last_byte;
      end else begin
        case (state)
          IDLE: if (result_valid) begin
            shreg    <= result_in;
            byte_cnt <= '0;
            state    <= ARM;
            ready    <= 1'b0;
          end
          ARM: if (!tx_busy) begin
            state                 <= START;
            tx_start_transmission <= 1'b1;
            tx_data_in            <= cur_byte;
          end
          START: begin
            state  <= WAIT_HI;
            to_cnt <= '0;
          end
          WAIT_HI: if (tx_busy) state <= WAIT_LO;
                   else to_cnt <= to_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_result_serializer.sv
// tb_mac_result_serializer: LSB-first and MSB-first instances share one UART model and are checked against a byte-queue reference.
module tb_mac_result_serializer;
  localparam int W = 48;
  localparam int N = 6;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] result_in = '0;
  logic result_valid = 1'b0;
  logic tx_busy;
  logic force_busy = 1'b0, uart_busy = 1'b0, stuck0 = 1'b0;
  logic ready_l, start_l, done_l, ovr_l, ready_m, start_m, done_m, ovr_m;
  logic [7:0] data_l, data_m;
  int errors = 0, checks = 0;
  int u_delay = 0, u_len = 0, u_nlen = 0, udel_lo = 1, udel_hi = 1, ulen_lo = 10, ulen_hi = 10;
  logic [7:0] q_l[$], q_m[$], sent_l[$], sent_m[$];
  logic [7:0] d_l = '0, d_m = '0;
  logic active = 0, ovr_exp = 0, prev_busy = 0, prev_start = 0, prev_done = 0, lat_pending = 0;
  int cyc = 0, starts = 0, dones = 0, last_start = 0, gap = 0, acc_cyc = 0, lat = 0;
  always #5 clk = ~clk;
  assign tx_busy = force_busy | uart_busy;
  mac_result_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b1), .ACCEPT_TIMEOUT(TO)) dut_l (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid), .ready(ready_l),
    .tx_busy(tx_busy), .tx_start_transmission(start_l), .tx_data_in(data_l), .frame_done(done_l), .overrun(ovr_l));
  mac_result_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b0), .ACCEPT_TIMEOUT(TO)) dut_m (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid), .ready(ready_m),
    .tx_busy(tx_busy), .tx_start_transmission(start_m), .tx_data_in(data_m), .frame_done(done_m), .overrun(ovr_m));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // UART model: busy rises u_delay cycles after a start pulse and stays high for u_nlen cycles.
  initial forever begin
    @(posedge clk); #1;
    if (reset) begin
      uart_busy = 0; u_delay = 0; u_len = 0;
    end else begin
      if (u_delay > 0) begin
        u_delay--;
        if (u_delay == 0) begin uart_busy = 1; u_len = u_nlen; end
      end else if (uart_busy) begin
        u_len--;
        if (u_len == 0) uart_busy = 0;
      end
      if (start_l && !stuck0) begin
        u_delay = $urandom_range(udel_hi, udel_lo);
        u_nlen  = $urandom_range(ulen_hi, ulen_lo);
      end
    end
  end
  // Reference model: each accepted result becomes a queue of expected bytes; outputs checked every cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q_l.delete(); q_m.delete(); d_l = 0; d_m = 0; active = 0; ovr_exp = 0; lat_pending = 0;
    end
    if (start_l) begin
      chk("start_while_busy", prev_busy, 0);
      chk("start_width", prev_start, 0);
      chk("start_expected", q_l.size() != 0, 1);
      if (q_l.size() != 0) begin
        d_l = q_l.pop_front(); d_m = q_m.pop_front();
      end
      sent_l.push_back(data_l); sent_m.push_back(data_m);
      starts++;
      gap = cyc - last_start; last_start = cyc;
      if (lat_pending) begin lat = cyc - acc_cyc; lat_pending = 0; end
    end
    if (done_l) begin
      chk("done_in_frame", active, 1);
      chk("done_bytes_left", q_l.size(), 0);
      chk("done_after_busy_low", prev_busy, 0);
      chk("done_width", prev_done, 0);
      active = 0;
      dones++;
    end
    chk("start_m", start_m, start_l);
    chk("data_l", data_l, d_l);
    chk("data_m", data_m, d_m);
    chk("ready_l", ready_l, !active);
    chk("ready_m", ready_m, !active);
    chk("done_m", done_m, done_l);
    chk("overrun_l", ovr_l, ovr_exp);
    chk("overrun_m", ovr_m, ovr_exp);
    if (!reset && result_valid) begin
      if (active) ovr_exp = 1;
      else begin
        active = 1; acc_cyc = cyc; lat_pending = 1;
        for (int i = 0; i < N; i++) begin
          q_l.push_back(result_in[8*i +: 8]);
          q_m.push_back(result_in[W-1-8*i -: 8]);
        end
      end
    end
    prev_busy = tx_busy; prev_start = start_l; prev_done = done_l;
  end
  task automatic pulse(input logic [W-1:0] v);
    @(posedge clk); #1;
    result_in = v; result_valid = 1;
    @(posedge clk); #1;
    result_valid = 0;
  endtask
  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (dones < target && n < budget) begin @(posedge clk); n++; end
    chk(name, dones >= target, 1);
  endtask
  task automatic wait_starts(input int target, input int budget, input string name);
    int n = 0;
    while (starts < target && n < budget) begin @(posedge clk); n++; end
    chk(name, starts >= target, 1);
  endtask
  task automatic check_frame(input logic [W-1:0] v, input string name);
    chk({name, "_count"}, sent_l.size(), N);
    if (sent_l.size() == N)
      for (int i = 0; i < N; i++) begin
        chk({name, "_lsb"}, sent_l[i], v[8*i +: 8]);
        chk({name, "_msb"}, sent_m[i], v[W-1-8*i -: 8]);
      end
    sent_l.delete(); sent_m.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, d0;
    logic [W-1:0] v;
    logic fb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready_l, 1);
    chk("reset_start", start_l, 0);
    chk("reset_data", data_l, 0);
    chk("reset_done", done_l, 0);
    chk("reset_overrun", ovr_l, 0);
    reset = 0;
    // Basic LSB-first frame with latency and single frame_done
    sent_l.delete(); sent_m.delete();
    s0 = starts; d0 = dones;
    pulse(48'h0000_0000_0032);
    wait_done(d0 + 1, 400, "t1_done");
    repeat (5) @(posedge clk);
    chk("t1_latency", lat, 2);
    chk("t1_starts", starts - s0, 6);
    chk("t1_done_once", dones - d0, 1);
    chk("t1_overrun", ovr_l, 0);
    chk("t1_byte0", sent_l[0], 8'h32);
    chk("t1_byte1", sent_l[1], 8'h00);
    chk("t1_msb_last", sent_m[5], 8'h32);
    check_frame(48'h0000_0000_0032, "t1");
    // MSB-first ordering
    d0 = dones;
    pulse(48'h0102_0304_0506);
    wait_done(d0 + 1, 400, "t2_done");
    chk("t2_msb0", sent_m[0], 8'h01);
    chk("t2_msb5", sent_m[5], 8'h06);
    chk("t2_lsb0", sent_l[0], 8'h06);
    check_frame(48'h0102_0304_0506, "t2");
    // Foreign traffic keeps the UART busy when the result arrives
    @(posedge clk); #1 force_busy = 1;
    s0 = starts; d0 = dones;
    pulse(48'hDEAD_BEEF_CAFE);
    repeat (18) @(posedge clk);
    chk("t3_no_start", starts, s0);
    chk("t3_waiting", ready_l, 0);
    #1 force_busy = 0;
    wait_done(d0 + 1, 400, "t3_done");
    chk("t3_starts", starts - s0, 6);
    check_frame(48'hDEAD_BEEF_CAFE, "t3");
    // Second result during byte 3 is dropped
    s0 = starts; d0 = dones;
    pulse(48'hA1A2_A3A4_A5A6);
    wait_starts(s0 + 3, 200, "t4_byte3");
    pulse(48'h1111_2222_3333);
    wait_done(d0 + 1, 400, "t4_done");
    chk("t4_overrun", ovr_l, 1);
    chk("t4_ready", ready_l, 1);
    chk("t4_starts", starts - s0, 6);
    check_frame(48'hA1A2_A3A4_A5A6, "t4");
    // UART never acknowledges: each byte times out
    @(posedge clk); #1 stuck0 = 1;
    s0 = starts; d0 = dones;
    pulse(48'h0F1E_2D3C_4B5A);
    wait_done(d0 + 1, 200, "t5_done");
    chk("t5_starts", starts - s0, 6);
    chk("t5_gap", gap, TO + 2);
    chk("t5_overrun_sticky", ovr_l, 1);
    check_frame(48'h0F1E_2D3C_4B5A, "t5");
    #1 stuck0 = 0;
    // Reset during WAIT_LO of byte 2 aborts the frame
    s0 = starts;
    pulse(48'h7766_5544_3322);
    wait_starts(s0 + 3, 200, "t6_byte2");
    for (int n = 0; n < 20 && !tx_busy; n++) @(negedge clk);
    chk("t6_busy_seen", tx_busy, 1);
    @(negedge clk); #2 reset = 1;
    #1;
    chk("t6_async_start", start_l, 0);
    chk("t6_async_data_l", data_l, 0);
    chk("t6_async_data_m", data_m, 0);
    chk("t6_async_ready", ready_l, 1);
    chk("t6_async_overrun", ovr_l, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    s0 = starts;
    repeat (30) @(posedge clk);
    chk("t6_no_more_starts", starts, s0);
    sent_l.delete(); sent_m.delete();
    d0 = dones;
    pulse(48'h89AB_CDEF_0123);
    wait_done(d0 + 1, 400, "t6_done");
    chk("t6_starts", starts - s0, 6);
    check_frame(48'h89AB_CDEF_0123, "t6");
    // Randomized frames, UART timing, foreign busy and extra pulses
    for (int it = 0; it < 30; it++) begin
      udel_lo = 1; udel_hi = $urandom_range(1, 3);
      ulen_lo = 1; ulen_hi = $urandom_range(1, 12);
      fb = ($urandom_range(0, 3) == 0);
      if (fb) begin @(posedge clk); #1 force_busy = 1; end
      v = {$urandom, $urandom};
      d0 = dones;
      pulse(v);
      if (fb) begin repeat ($urandom_range(1, 15)) @(posedge clk); #1 force_busy = 0; end
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        pulse({$urandom, $urandom});
      end
      wait_done(d0 + 1, 600, "rand_done");
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    repeat (300) @(posedge clk);
    chk("end_idle", ready_l, 1);
    chk("end_queue_empty", q_l.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_result_serializer.md
Name: mac_result_serializer

Overview:
- Downstream of the MAC stimulus stage. Takes the 48-bit MAC accumulator result (data_p) when a one-cycle valid pulse arrives.
- Sends the result as a sequence of bytes through the uart_core transmitter interface (tx_start_transmission / tx_busy / tx_data_in).
- Replaces the present "send DATA_P[7:0] only" path, so the host receives the full product.
- Keeps per-byte handshaking, so no byte is issued while the UART is busy.

Parameters:
- DATA_WIDTH, 48, width of result_in; must be a multiple of 8.
- NUM_BYTES, DATA_WIDTH/8, number of bytes sent per result.
- LSB_FIRST, 1, 1 = byte 0 is result_in[7:0]; 0 = byte 0 is the most significant byte.
- ACCEPT_TIMEOUT, 8, cycles to wait for tx_busy to rise after a start pulse before treating the byte as sent.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- result_in  input  DATA_WIDTH  MAC result (data_p); sampled only on an accepted result_valid.
- result_valid  input  1  one-cycle pulse: result_in is valid.
- ready  output  1  high only in IDLE; result_valid is accepted only when ready=1.
- tx_busy  input  1  UART transmitter busy.
- tx_start_transmission  output  1  one-cycle start pulse to uart_core.
- tx_data_in  output  8  byte to transmit; stable from the start pulse until tx_busy falls.
- frame_done  output  1  one-cycle pulse after the last byte completes.
- overrun  output  1  sticky flag: a result_valid was dropped; cleared only by reset.

Behaviour:
- Reset (async, immediate): state=IDLE, ready=1, tx_start_transmission=0, tx_data_in=0, frame_done=0, overrun=0, byte counter=0, shift register=0.
- A reset mid-frame aborts the frame immediately; the remaining bytes are never sent.
- States: IDLE, ARM, START, WAIT_HI, WAIT_LO.
- IDLE:
  - result_valid=1 at edge N: capture result_in into the shift register, set byte counter=0, go to ARM.
  - ready=0 from N+1.
- ARM:
  - If tx_busy=0, go to START.
  - Otherwise hold in ARM. This protects against a UART still busy with foreign traffic.
- START:
  - Lasts exactly one cycle, with tx_start_transmission=1.
  - tx_data_in holds the current byte: shreg[7:0] if LSB_FIRST, else shreg[DATA_WIDTH-1 -: 8].
  - Then go to WAIT_HI and clear the timeout counter.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Timeout counter reaches ACCEPT_TIMEOUT-1 with tx_busy still 0: treat the byte as done and take the WAIT_LO exit path directly.
- WAIT_LO (tx_busy=0 exit path):
  - Shift shreg by 8 in the direction set by LSB_FIRST, and increment the byte counter.
  - If counter was NUM_BYTES-1: go to IDLE and pulse frame_done for one cycle (the cycle IDLE is entered).
  - Otherwise go to ARM.
- Latency from an accepted result_valid to the first tx_start_transmission is 2 cycles when tx_busy=0 (edge N to ARM, N+1 to START).
- tx_data_in changes only when entering START. It is held across WAIT_HI/WAIT_LO and keeps its last value in IDLE.
- result_valid while ready=0: the input is dropped, overrun is set to 1, and the frame in progress is unaffected.
  - This includes the cycle in which WAIT_LO exits to IDLE; the input is accepted only from the following cycle.
- result_valid and tx_busy=1 together in IDLE: the result is accepted and the block waits in ARM.
- Byte counter width is clog2(NUM_BYTES)+1. There is no wrap-around within a frame.

Test Plan:
- Reset, then result_in=48'h0000_0000_0032 pulsed, with a UART model (busy 1 cycle after start, for 10 cycles) -> bytes 32,00,00,00,00,00 in order; first start 2 cycles after the pulse; frame_done once; overrun=0.
- LSB_FIRST=0, result_in=48'h0102_0304_0506 -> bytes 01,02,03,04,05,06.
- tx_busy held high for 20 cycles when result_valid arrives -> no start pulse until tx_busy falls; then the normal 6-byte frame.
- Second result_valid during byte 3 -> dropped; overrun=1 and stays 1; the frame completes with the original bytes; ready returns to 1 after frame_done.
- tx_busy never rises (stuck 0) -> each byte advances after ACCEPT_TIMEOUT cycles; 6 start pulses; frame_done asserted.
- Reset asserted during WAIT_LO of byte 2 -> tx_start_transmission=0, tx_data_in=0, ready=1 asynchronously; no further start pulses; a new result is then sent in full.
